// File: rtl/nn_pkg.sv
// Shared types and constants for the NN lane loader and its lane buffers.
package nn_pkg;

   typedef enum logic {
      LD_IDLE  = 1'b0,
      LD_DRAIN = 1'b1
   } loader_state_t;

   localparam int NN_DW = 16;

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane circular buffer with head peek; a push and a pop on a full buffer in
// the same cycle both succeed and leave the count unchanged.
module lane_fifo
   import nn_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = NN_DW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DW-1:0]              din,
   output logic [DW-1:0]              dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = clog2_min1(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok_s, pop_ok_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign dout  = mem_q[rd_q];

   // Accept/pointer/count next-state; a pop frees the slot a same-cycle push needs.
   always_comb begin
      pop_ok_s  = pop && !empty;
      push_ok_s = push && (!full || pop_ok_s);
      rd_d      = pop_ok_s  ? ptr_inc(rd_q) : rd_q;
      wr_d      = push_ok_s ? ptr_inc(wr_q) : wr_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents are meaningless while the count says empty.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_q] <= din;
      end
   end

endmodule

// File: rtl/nn_lane_loader.sv
// Skewed systolic lane loader: writes fill per-lane FIFOs, start drains them with
// lane k delayed by k cycles. Build option NN_LOADER_FEEDBACK_EN enables fb_* refill.
module nn_lane_loader
   import nn_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DEPTH = 4,
   parameter int DW    = NN_DW
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [clog2_min1(LANES)-1:0] wr_addr,
   input  logic signed [DW-1:0]         wr_data,
   input  logic                         start,
   input  logic                         fb_sel,
   input  logic [LANES-1:0]             fb_valid,
   input  logic [LANES*DW-1:0]          fb_data,
   output logic [LANES*DW-1:0]          out_data,
   output logic [LANES-1:0]             out_valid,
   output logic                         busy,
   output logic                         ovf_err
);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int KW    = $clog2(LANES + DEPTH + 1);
   localparam int C_MAX = LANES + DEPTH;

   loader_state_t            state_q, state_d;
   logic [KW-1:0]            c_q, c_d;
   logic [LANES-1:0][CW-1:0] snap_q, snap_d, emit_q, emit_d;
   logic [LANES*DW-1:0]      out_data_q;
   logic [LANES-1:0]         out_valid_q;
   logic                     ovf_q;

   logic [LANES-1:0] push_s, pop_s, fb_take_s, fb_drop_s, full_s, empty_s;
   logic [DW-1:0]    din_s   [LANES];
   logic [DW-1:0]    head_s  [LANES];
   logic [CW-1:0]    count_s [LANES];
   logic             host_drop_s, ovf_set_s, all_done_s;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_s[g]),
         .pop   (pop_s[g]),
         .din   (din_s[g]),
         .dout  (head_s[g]),
         .full  (full_s[g]),
         .empty (empty_s[g]),
         .count (count_s[g])
      );
   end

`ifndef NN_LOADER_FEEDBACK_EN
   logic unused_fb_s;
   assign unused_fb_s = ^{fb_sel, fb_valid, fb_data};
`endif

   // Write steering: feedback owns its lane for the cycle, host writes take what is left.
   always_comb begin
      push_s      = '0;
      fb_take_s   = '0;
      fb_drop_s   = '0;
      host_drop_s = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         din_s[k] = wr_data;
      end
`ifdef NN_LOADER_FEEDBACK_EN
      for (int k = 0; k < LANES; k++) begin
         if (fb_sel && fb_valid[k]) begin
            fb_take_s[k] = 1'b1;
            din_s[k]     = fb_data[k*DW +: DW];
            if (full_s[k] && !pop_s[k]) begin
               fb_drop_s[k] = 1'b1;
            end else begin
               push_s[k] = 1'b1;
            end
         end else begin
            fb_take_s[k] = 1'b0;
         end
      end
`endif
      if (!wr_en) begin
         host_drop_s = 1'b0;
      end else if (int'(wr_addr) >= LANES || fb_take_s[wr_addr]) begin
         host_drop_s = 1'b1;
      end else if (full_s[wr_addr] && !pop_s[wr_addr]) begin
         host_drop_s = 1'b1;
      end else begin
         push_s[wr_addr] = 1'b1;
      end
      ovf_set_s = host_drop_s | (|fb_drop_s);
   end

   // Drain FSM: lane k pops once the skew counter reaches k, until its snapshot is spent.
   always_comb begin
      state_d    = state_q;
      c_d        = c_q;
      snap_d     = snap_q;
      emit_d     = emit_q;
      pop_s      = '0;
      all_done_s = 1'b1;
      case (state_q)
         LD_IDLE: begin
            if (start) begin
               state_d = LD_DRAIN;
               c_d     = '0;
               emit_d  = '0;
               for (int k = 0; k < LANES; k++) begin
                  snap_d[k] = count_s[k];
               end
            end else begin
               state_d = LD_IDLE;
            end
         end
         LD_DRAIN: begin
            for (int k = 0; k < LANES; k++) begin
               if (emit_q[k] != snap_q[k]) begin
                  all_done_s = 1'b0;
                  if (int'(c_q) >= k && !empty_s[k]) begin
                     pop_s[k]  = 1'b1;
                     emit_d[k] = emit_q[k] + CW'(1);
                  end else begin
                     pop_s[k] = 1'b0;
                  end
               end else begin
                  pop_s[k] = 1'b0;
               end
            end
            if (all_done_s) begin
               state_d = LD_IDLE;
            end else begin
               state_d = LD_DRAIN;
            end
            c_d = (c_q == KW'(C_MAX)) ? c_q : c_q + KW'(1);
         end
         default: state_d = LD_IDLE;
      endcase
   end

   // Control state, sticky overflow and the registered lane outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= LD_IDLE;
         c_q         <= '0;
         snap_q      <= '0;
         emit_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         snap_q      <= snap_d;
         emit_q      <= emit_d;
         ovf_q       <= ovf_q | ovf_set_s;
         out_valid_q <= pop_s;
         for (int k = 0; k < LANES; k++) begin
            out_data_q[k*DW +: DW] <= pop_s[k] ? head_s[k] : '0;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == LD_DRAIN);
   assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_nn_lane_loader.sv
// Directed and randomized bench for nn_lane_loader against a queue/timeline model.
module tb_nn_lane_loader;
   localparam int LANES = 2;
   localparam int DEPTH = 4;
   localparam int DW    = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  wr_en;
   logic [0:0]            wr_addr;
   logic signed [DW-1:0]  wr_data;
   logic                  start;
   logic                  fb_sel;
   logic [LANES-1:0]      fb_valid;
   logic [LANES*DW-1:0]   fb_data;
   logic [LANES*DW-1:0]   out_data;
   logic [LANES-1:0]      out_valid;
   logic                  busy;
   logic                  ovf_err;

   always #5 clk = ~clk;

   nn_lane_loader #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .fb_sel(fb_sel), .fb_valid(fb_valid), .fb_data(fb_data),
      .out_data(out_data), .out_valid(out_valid), .busy(busy), .ovf_err(ovf_err)
   );

   int vectors = 0;
   int fails   = 0;

   // Reference model: lane contents as queues, drain as a timeline relative to start.
   logic [DW-1:0]    mq [LANES][$];
   int               m_snap [LANES];
   int               m_rel  = 0;
   int               m_end  = 0;
   bit               m_busy = 1'b0;
   bit               m_ovf  = 1'b0;
   logic [LANES-1:0] e_valid;
   logic [DW-1:0]    e_data [LANES];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit [LANES-1:0] fb_took;
      int i;
      e_valid = '0;
      for (int k = 0; k < LANES; k++) e_data[k] = '0;
      if (!rst) begin
         for (int k = 0; k < LANES; k++) mq[k].delete();
         m_busy = 1'b0;
         m_ovf  = 1'b0;
         m_rel  = 0;
         return;
      end
      if (m_busy) begin
         m_rel++;
         for (int k = 0; k < LANES; k++) begin
            i = m_rel - 1 - k;
            if (i >= 0 && i < m_snap[k]) begin
               e_valid[k] = 1'b1;
               e_data[k]  = mq[k].pop_front();
            end
         end
         if (m_rel >= m_end) m_busy = 1'b0;
      end else if (start) begin
         m_busy = 1'b1;
         m_rel  = 0;
         m_end  = 1;
         for (int k = 0; k < LANES; k++) begin
            m_snap[k] = mq[k].size();
            if (m_snap[k] > 0 && 1 + k + m_snap[k] > m_end) m_end = 1 + k + m_snap[k];
         end
      end
      fb_took = '0;
`ifdef NN_LOADER_FEEDBACK_EN
      for (int k = 0; k < LANES; k++) begin
         if (fb_sel && fb_valid[k]) begin
            fb_took[k] = 1'b1;
            if (mq[k].size() < DEPTH) mq[k].push_back(fb_data[k*DW +: DW]);
            else m_ovf = 1'b1;
         end
      end
`endif
      if (wr_en) begin
         if (int'(wr_addr) >= LANES || fb_took[wr_addr] || mq[wr_addr].size() >= DEPTH) m_ovf = 1'b1;
         else mq[wr_addr].push_back(wr_data);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      for (int k = 0; k < LANES; k++) begin
         chk($sformatf("valid_l%0d", k), 64'(out_valid[k]), 64'(e_valid[k]));
         chk($sformatf("data_l%0d", k), 64'(out_data[k*DW +: DW]), 64'(e_data[k]));
      end
      chk("busy", 64'(busy), 64'(m_busy));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = 1'b0; wr_data = '0; start = 1'b0;
      fb_sel = 1'b0; fb_valid = '0; fb_data = '0;
   endtask

   task automatic wr(input logic [0:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic reset_pulse();
      rst = 1'b0; step(); rst = 1'b1;
   endtask

   initial begin
      int n;
      logic [DW-1:0] cap;
      rst = 1'b0;
      idle_inputs();
      step(); step();
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_data", 64'(out_data), 64'd0);
      rst = 1'b1;
      step();

      // Two-lane skew
      wr(1'b0, 16'd5); wr(1'b0, 16'd6); wr(1'b1, 16'd7); wr(1'b1, 16'd8);
      start = 1'b1; step(); start = 1'b0;
      chk("skew_busy_t", 64'(busy), 64'd1);
      step();
      chk("skew_l0_5", 64'(out_data[15:0]), 64'd5);
      chk("skew_l1_quiet", 64'(out_valid[1]), 64'd0);
      step();
      chk("skew_l0_6", 64'(out_data[15:0]), 64'd6);
      chk("skew_l1_7", 64'(out_data[31:16]), 64'd7);
      step();
      chk("skew_l1_8", 64'(out_data[31:16]), 64'd8);
      chk("skew_l0_done", 64'(out_valid[0]), 64'd0);
      chk("skew_busy_t3", 64'(busy), 64'd1);
      step();
      chk("skew_busy_fall", 64'(busy), 64'd0);

      // Overflow, plus push+pop on a full lane during the drain
      reset_pulse();
      for (int i = 1; i <= 5; i++) wr(1'b1, 16'(i));
      chk("ovf_flag", 64'(ovf_err), 64'd1);
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin wr_en = 1'b1; wr_addr = 1'b1; wr_data = 16'd99; end
         step();
         wr_en = 1'b0;
         n += int'(out_valid[1]);
      end
      chk("ovf_drain_len", 64'(n), 64'd4);
      start = 1'b1; step(); start = 1'b0;
      repeat (4) step();

`ifdef NN_LOADER_FEEDBACK_EN
      // Feedback collision: feedback wins lane0
      reset_pulse();
      fb_sel = 1'b1; fb_valid = 2'b01; fb_data = {16'd0, 16'hFFFD};
      wr(1'b0, 16'd9);
      idle_inputs();
      chk("fb_ovf", 64'(ovf_err), 64'd1);
      start = 1'b1; step(); start = 1'b0;
      n = 0; cap = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (out_valid[0]) begin n++; cap = out_data[15:0]; end
      end
      chk("fb_count", 64'(n), 64'd1);
      chk("fb_value", 64'(cap), 64'hFFFD);
`else
      // Feedback disabled: fb ports must not fill lanes
      reset_pulse();
      fb_sel = 1'b1; fb_valid = 2'b11; fb_data = 32'h1234_5678;
      repeat (3) step();
      idle_inputs();
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin step(); n += int'(|out_valid); end
      chk("nofb_emits", 64'(n), 64'd0);
      chk("nofb_ovf", 64'(ovf_err), 64'd0);
`endif

      // Mid-drain reset
      reset_pulse();
      for (int i = 0; i < DEPTH; i++) begin wr(1'b0, 16'(100 + i)); wr(1'b1, 16'(200 + i)); end
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      rst = 1'b0; step(); rst = 1'b1;
      chk("mdr_valid", 64'(out_valid), 64'd0);
      chk("mdr_busy", 64'(busy), 64'd0);
      step();
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin step(); n += int'(|out_valid); end
      chk("mdr_restart_emits", 64'(n), 64'd0);

      // Start while busy, unequal lanes
      reset_pulse();
      wr(1'b0, 16'd10); wr(1'b0, 16'd11); wr(1'b0, 16'd12); wr(1'b1, 16'd20);
      start = 1'b1; step();
      step(); start = 1'b0;
      step();
      chk("sb_l1_valid", 64'(out_valid[1]), 64'd1);
      chk("sb_l1_data", 64'(out_data[31:16]), 64'd20);
      step();
      chk("sb_l1_once", 64'(out_valid[1]), 64'd0);
      chk("sb_busy_t3", 64'(busy), 64'd1);
      step();
      chk("sb_idle_t4", 64'(busy), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(63) != 0);
         wr_en    = 1'($urandom_range(1));
         wr_addr  = 1'($urandom_range(1));
         wr_data  = DW'($urandom);
         start    = ($urandom_range(7) == 0);
         fb_sel   = 1'($urandom_range(1));
         fb_valid = LANES'($urandom_range(3));
         fb_data  = $urandom;
         step();
      end
      rst = 1'b1;
      idle_inputs();
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
